// File: rtl/ysyx_23060203_pkg.sv
// Shared opcode constants, CU state encoding and opcode classification helpers.
// Used by both the control unit and the instruction decoder.
package ysyx_23060203_pkg;

  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_CALRI  = 5'b00100;
  localparam logic [4:0] OP_CALRR  = 5'b01100;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  localparam logic [2:0] FUNCT_HALT = 3'b000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH_REQ,
    ST_FETCH_RSP,
    ST_DECODE,
    ST_EXEC,
    ST_MEM_REQ,
    ST_MEM_RSP,
    ST_WB,
    ST_HALT,
    ST_ERROR
  } cu_state_e;

  function automatic logic is_legal_op(input logic [4:0] op);
    logic legal;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_CALRI, OP_CALRR, OP_SYSTEM: legal = 1'b1;
      default:                                          legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/ysyx_23060203_cu_perfcnt.sv
// Free-running cycle and retired-instruction counters for the control unit.
// Only instantiated when YSYX_23060203_PERF_EN is defined.
module ysyx_23060203_PERFCNT (
  input  logic        clk,
  input  logic        rstn,
  input  logic        count_cycle,
  input  logic        count_instret,
  output logic [31:0] perf_cycle,
  output logic [31:0] perf_instret
);

  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      if (count_cycle)   cycle_q   <= cycle_q + 32'd1;
      if (count_instret) instret_q <= instret_q + 32'd1;
    end
  end

  assign perf_cycle   = cycle_q;
  assign perf_instret = instret_q;

endmodule

// File: rtl/ysyx_23060203_cu.sv
// Multi-cycle control unit: sequences fetch, decode, execute, memory and write-back.
// Define YSYX_23060203_PERF_EN to add the perf_cycle / perf_instret counters.
module ysyx_23060203_cu
  import ysyx_23060203_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  opcode,
  input  logic [2:0]  funct,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic        inst_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        commit,
  output logic        halted,
  output logic        error
`ifdef YSYX_23060203_PERF_EN
  ,
  output logic [31:0] perf_cycle,
  output logic [31:0] perf_instret
`endif
);

  cu_state_e state;
  cu_state_e next_state;
  logic      wb_rf_q;

  // The regfile write decision is captured in EXEC so WB depends only on registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      wb_rf_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_EXEC) wb_rf_q <= !((opcode == OP_BRANCH) || (opcode == OP_STORE));
    end
  end

  always_comb begin
    next_state    = state;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    inst_we       = 1'b0;
    rf_we         = 1'b0;
    pc_we         = 1'b0;
    commit        = 1'b0;
    halted        = 1'b0;
    error         = 1'b0;
    case (state)
      ST_IDLE:      next_state = ST_FETCH_REQ;
      ST_FETCH_REQ: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) next_state = ST_FETCH_RSP;
      end
      // inst_we qualifies the IR load on the exact cycle the fetch data is present.
      ST_FETCH_RSP: begin
        if (ifu_rsp_valid) begin
          inst_we    = 1'b1;
          next_state = ST_DECODE;
        end
      end
      ST_DECODE:    next_state = ST_EXEC;
      ST_EXEC: begin
        if (is_mem_op(opcode))                                  next_state = ST_MEM_REQ;
        else if ((opcode == OP_SYSTEM) && (funct == FUNCT_HALT)) next_state = ST_HALT;
        else if (!is_legal_op(opcode))                          next_state = ST_ERROR;
        else                                                    next_state = ST_WB;
      end
      ST_MEM_REQ: begin
        lsu_req_valid = 1'b1;
        if (lsu_req_ready) next_state = ST_MEM_RSP;
      end
      ST_MEM_RSP: begin
        if (lsu_rsp_valid) next_state = ST_WB;
      end
      ST_WB: begin
        pc_we      = 1'b1;
        commit     = 1'b1;
        rf_we      = wb_rf_q;
        next_state = ST_FETCH_REQ;
      end
      ST_HALT:  halted = 1'b1;
      ST_ERROR: error  = 1'b1;
      default:  next_state = ST_ERROR;
    endcase
  end

`ifdef YSYX_23060203_PERF_EN
  ysyx_23060203_PERFCNT u_perf (
    .clk           (clk),
    .rstn          (rstn),
    .count_cycle   ((state != ST_IDLE) && (state != ST_HALT) && (state != ST_ERROR)),
    .count_instret (commit),
    .perf_cycle    (perf_cycle),
    .perf_instret  (perf_instret)
  );
`endif

endmodule
